// File: rtl/console_tx_if.sv
// CPU data-bus view of the console transmitter: independent write and read
// channels, each with its own word address and strobe.
interface console_tx_if;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] raddr;
    logic        re;
    logic [15:0] rdata;

    modport master (output waddr, output wdata, output we,
                    output raddr, output re, input rdata);
    modport slave  (input waddr, input wdata, input we,
                    input raddr, input re, output rdata);
endinterface

// File: rtl/console_tx.sv
// Memory-mapped 8N1 console transmitter: DATA writes feed a byte FIFO that a
// shifter drains onto txd at a programmable clocks-per-bit divisor.
module console_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd4
) (
    input  logic         clk,
    input  logic         rst,
    console_tx_if.slave  bus,
    output logic         txd,
    output logic         irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t        state_r;
    logic [15:0]   div_r;
    logic [15:0]   div_lat_r;
    logic [15:0]   timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shreg_r;
    logic          txd_r;
    logic          ovf_r;
    logic [15:0]   rdata_r;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic          wsel_s;
    logic          rsel_s;
    logic          full_s;
    logic          empty_s;
    logic          push_req_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic          div_wr_s;
    logic          pop_s;
    logic [15:0]   div_eff_s;
    logic [15:0]   status_s;
    logic [15:0]   rdata_next_s;

    assign wsel_s     = bus.we && (bus.waddr[15:2] == BASE_ADDR[15:2]);
    assign rsel_s     = bus.re && (bus.raddr[15:2] == BASE_ADDR[15:2]);
    assign full_s     = (count_r == FULL_CNT);
    assign empty_s    = (count_r == {CW{1'b0}});
    assign push_req_s = wsel_s && (bus.waddr[1:0] == 2'd0);
    assign push_s     = push_req_s && !full_s;
    assign ovf_set_s  = push_req_s && full_s;
    assign ovf_clr_s  = wsel_s && (bus.waddr[1:0] == 2'd1) && bus.wdata[3];
    assign div_wr_s   = wsel_s && (bus.waddr[1:0] == 2'd2);
    assign pop_s      = (state_r == ST_IDLE) && !empty_s;
    assign div_eff_s  = (div_r == 16'd0) ? 16'd1 : div_r;

    assign bus.rdata  = rdata_r;
    assign txd        = txd_r;
    assign irq        = empty_s && (state_r == ST_IDLE);

    // Status word assembly and read-data selection from pre-edge state.
    always_comb begin
        status_s          = 16'h0000;
        status_s[0]       = (state_r != ST_IDLE);
        status_s[1]       = full_s;
        status_s[2]       = empty_s;
        status_s[3]       = ovf_r;
        status_s[8 +: CW] = count_r;
        rdata_next_s      = 16'h0000;
        if (rsel_s) begin
            case (bus.raddr[1:0])
                2'd1:    rdata_next_s = status_s;
                2'd2:    rdata_next_s = div_r;
                default: rdata_next_s = 16'h0000;
            endcase
        end else begin
            rdata_next_s = 16'h0000;
        end
    end

    // Register block: divisor, sticky overflow and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r   <= DIV_RESET;
            ovf_r   <= 1'b0;
            rdata_r <= 16'h0000;
        end else begin
            if (div_wr_s) begin
                div_r <= bus.wdata;
            end
            // A dropped push in the same cycle beats a clear request.
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
            rdata_r <= rdata_next_s;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame FSM; txd is registered from the current state, so the line
    // trails the state by one clock and an extra idle cycle separates frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            div_lat_r <= 16'd1;
            timer_r   <= 16'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_START: txd_r <= 1'b0;
                ST_DATA:  txd_r <= shreg_r[0];
                default:  txd_r <= 1'b1;
            endcase
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shreg_r   <= mem_r[rd_ptr_r];
                        div_lat_r <= div_eff_s;
                        timer_r   <= div_eff_s - 16'd1;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_r == 16'd0) begin
                        timer_r   <= div_lat_r - 16'd1;
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (timer_r == 16'd0) begin
                        timer_r <= div_lat_r - 16'd1;
                        shreg_r <= {1'b0, shreg_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (timer_r == 16'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        timer_r <= timer_r - 16'd1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule
